fifo_byte_serializer: RTL
=========================

# fifo_byte_serializer

Read-side drain stage for `syn_fifo`. It pops WID-bit words from the FIFO whenever the FIFO is non-empty and emits each word as a stream of BW-bit bytes on a valid/ready interface, flagging the last byte of each word. It sits directly downstream of `syn_fifo`: it drives the FIFO's `rd_i`, watches `empty_o`, and consumes `rdata`.

## Interface
- `WID`, default 32: FIFO word width. Must be an integer multiple of BW.
- `BW`, default 8: output byte width.
- `MSB_FIRST`, default 1: 1 sends the most-significant byte first; 0 sends the least-significant byte first.
- `NB` (localparam) = WID/BW: bytes per word.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-low reset (0 = reset).
- `fifo_empty_i`  in  1: connects to FIFO `empty_o`.
- `fifo_rd_o`  out  1: connects to FIFO `rd_i`; one-cycle pop request.
- `fifo_rdata_i`  in  WID: connects to FIFO `rdata`; valid the cycle after `fifo_rd_o`=1.
- `byte_o`  out  BW: current output byte.
- `byte_valid_o`  out  1: `byte_o` is valid.
- `byte_ready_i`  in  1: downstream accepts the byte. A transfer occurs when valid and ready are both 1 on a rising edge.
- `last_o`  out  1: asserted with the final byte of a word.
- `busy_o`  out  1: state is not IDLE.
- `word_cnt_o`  out  16: count of fully transmitted words, wraps 0xFFFF→0.

## Operation
- The FSM has four states: IDLE, RD, CAP, SEND. The state register is reset asynchronously to IDLE.
- **IDLE:** if `fifo_empty_i`=0, go to RD; otherwise stay in IDLE.
- **RD:** `fifo_rd_o`=1, decoded from the state only. Next state is CAP unconditionally.
- **CAP:** load `fifo_rdata_i` into the WID-bit shift register, clear the byte index to 0, then go to SEND.
- **SEND:** `byte_valid_o`=1.
  - `byte_o` is the shift register's top BW bits when MSB_FIRST=1, or its bottom BW bits when MSB_FIRST=0.
  - On each transfer, shift by BW toward the output end, zero-filling, and increment the index.
  - `last_o`=1 when index = NB-1.
  - On the transfer of the last byte: increment `word_cnt_o`. Then go to RD if `fifo_empty_i`=0 in that same cycle; otherwise go to IDLE.
  - With no transfer, the state, shift register and index hold.
- `fifo_rd_o` is asserted only in RD, so there is exactly one pop per word. It is never asserted while `fifo_empty_i`=1 at the decision point, so the FIFO is never underflowed.
- Outputs are Moore or register-driven. There is no combinational path from `byte_ready_i` or `fifo_empty_i` to any output.
- `busy_o` = (state != IDLE).

## Timing
- **Reset values:** state IDLE, `fifo_rd_o`=0, `byte_valid_o`=0, `last_o`=0, `byte_o`=0, shift register 0, index 0, `word_cnt_o`=0, `busy_o`=0.
- **Reset mid-operation:** the in-flight word is dropped, with no partial `last_o` and no count increment. The FSM restarts from IDLE after `rst` rises.
- **Latency:** let edge E0 be the edge at which IDLE samples `fifo_empty_i`=0.
  - RD occupies cycle E0→E1.
  - CAP occupies E1→E2.
  - The first byte is valid from E2.
  - Minimum word duration is NB+2 cycles, i.e. 6 for the defaults.
- **Back-to-back words:** the last-byte transfer edge enters RD directly, giving 2 bubble cycles between words.
- **Backpressure:** while `byte_valid_o`=1 and `byte_ready_i`=0, `byte_o` and `last_o` are held stable. Valid is never withdrawn before the transfer.
- **NB=1:** every byte has `last_o`=1.

## Test plan
- **Single word, MSB first.** Defaults, FIFO holds 0xA1B2C3D4, `byte_ready_i`=1 throughout. Required: exactly one `fifo_rd_o` pulse, bytes A1, B2, C3, D4 on consecutive cycles, `last_o` only on D4, `word_cnt_o` 0→1, then IDLE with `busy_o`=0.
- **Backpressure.** Same word, `byte_ready_i`=0 for 3 cycles while B2 is presented. Required: `byte_o`=B2 with valid=1 held all 3 cycles, then C3, D4. No extra pop.
- **Back-to-back.** FIFO holds 0x11223344 and 0x55667788, ready=1. Required: 44 sent, then exactly 2 cycles with valid=0, then 55 (MSB first). Two pops total, `word_cnt_o`=2, and no pop once empty.
- **LSB first.** MSB_FIRST=0, word 0xA1B2C3D4. Required: D4, C3, B2, A1, with `last_o` on A1.
- **Empty FIFO.** `fifo_empty_i`=1 for 20 cycles. Required: `fifo_rd_o`=0, `byte_valid_o`=0 and `busy_o`=0 throughout.
- **Reset mid-word.** Drop `rst` after byte B2 transfers. Required: all outputs go to reset values immediately with `word_cnt_o`=0. After release with the FIFO still non-empty, a fresh RD pulse occurs 1 cycle after the first IDLE sample.

Source files
------------

// File: rtl/fifo_byte_serializer.sv
// Drains WID-bit words from syn_fifo and emits them as BW-bit bytes
// on a valid/ready stream, flagging the final byte of each word.
module fifo_byte_serializer #(
  parameter int WID       = 32,
  parameter int BW        = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fifo_empty_i,
  output logic           fifo_rd_o,
  input  logic [WID-1:0] fifo_rdata_i,
  output logic [BW-1:0]  byte_o,
  output logic           byte_valid_o,
  input  logic           byte_ready_i,
  output logic           last_o,
  output logic           busy_o,
  output logic [15:0]    word_cnt_o
);

  localparam int NB = WID / BW;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CAP,
    SEND
  } state_e;

  state_e         state_q, state_d;
  logic [WID-1:0] shift_q, shift_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           xfer;
  logic           at_last;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    at_last = (idx_q == IW'(NB - 1));
    xfer    = (state_q == SEND) && byte_ready_i;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty_i) begin
          state_d = RD;
        end
      end
      RD: begin
        state_d = CAP;
      end
      CAP: begin
        shift_d = fifo_rdata_i;
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (xfer) begin
          if (MSB_FIRST != 0) begin
            shift_d = shift_q << BW;
          end else begin
            shift_d = shift_q >> BW;
          end
          idx_d = idx_q + IW'(1);
          if (at_last) begin
            idx_d   = '0;
            cnt_d   = cnt_q + 16'd1;
            // Skip IDLE so the next pop follows the last byte directly
            state_d = fifo_empty_i ? IDLE : RD;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign byte_o = shift_q[WID-1 -: BW];
    end else begin : g_lsb
      assign byte_o = shift_q[BW-1:0];
    end
  endgenerate

  assign fifo_rd_o    = (state_q == RD);
  assign byte_valid_o = (state_q == SEND);
  assign last_o       = (state_q == SEND) && at_last;
  assign busy_o       = (state_q != IDLE);
  assign word_cnt_o   = cnt_q;

endmodule
